udc_dir_decoder: RTL and testbench

// Receive side of the up/down counter interface: watches a sampled count stream (4-bit binary or

---
 rtl/udc_dir_decoder.sv | 157 +++++++++++++++
 tb/tb_udc_dir_decoder.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/udc_dir_decoder.sv
// udc_dir_decoder: receive-side monitor for an up/down (binary or decade) count stream.
// Classifies each strobed sample against the previous one, recovers the counting
// direction and flags wraps, holds, reversals, illegal steps and out-of-range values.
// Optional feature macro: UDC_REV_COUNT_EN (saturating 8-bit reversal counter on rev_cnt).
// Handshake: q_in is consumed on every rising clk edge where q_en=1; there is no
// backpressure. All outputs are registered and reflect the sample taken at the
// preceding edge; with q_en=0 the state holds and every pulse output is 0.
module udc_dir_decoder #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] q_in,
  input  logic             q_en,
  output logic             dir,
  output logic             dir_valid,
  output logic             wrap_up,
  output logic             wrap_down,
  output logic             hold,
  output logic             reversal,
  output logic             step_err,
  output logic             range_err,
  output logic [7:0]       rev_cnt
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

  // INIT: no reference sample yet; ACQ: reference known, direction not locked;
  // TRACK: direction locked.
  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_ACQ   = 2'd1,
    ST_TRACK = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] prev, prev_n;
  logic             dir_n, dir_valid_n;
  logic             wrap_up_n, wrap_down_n, hold_n, reversal_n, step_err_n, range_err_n;

  logic [WIDTH-1:0] up_val, down_val;
  logic             in_range, is_up, is_down, is_hold;

  // Neighbour values of prev modulo MODULUS and classification of the sample.
  always_comb begin
    up_val   = (prev == MAX_VAL) ? '0 : prev + WIDTH'(1);
    down_val = (prev == '0) ? MAX_VAL : prev - WIDTH'(1);
    in_range = ({1'b0, q_in} < MOD_EXT);
    is_up    = (q_in == up_val);
    is_down  = (q_in == down_val);
    is_hold  = (q_in == prev);
  end

  // Next-state and next-output decode; out-of-range samples leave all state untouched.
  always_comb begin
    state_n     = state;
    prev_n      = prev;
    dir_n       = dir;
    dir_valid_n = dir_valid;
    wrap_up_n   = 1'b0;
    wrap_down_n = 1'b0;
    hold_n      = 1'b0;
    reversal_n  = 1'b0;
    step_err_n  = 1'b0;
    range_err_n = 1'b0;
    if (q_en) begin
      if (!in_range) begin
        range_err_n = 1'b1;
      end else begin
        prev_n = q_in;
        case (state)
          ST_INIT: begin
            state_n = ST_ACQ;
          end
          ST_ACQ: begin
            if (is_up || is_down) begin
              dir_n       = is_up;
              dir_valid_n = 1'b1;
              state_n     = ST_TRACK;
              wrap_up_n   = is_up && (prev == MAX_VAL);
              wrap_down_n = is_down && (prev == '0);
            end else if (is_hold) begin
              hold_n = 1'b1;
            end else begin
              step_err_n = 1'b1;
            end
          end
          ST_TRACK: begin
            if (is_up || is_down) begin
              dir_n       = is_up;
              reversal_n  = (is_up != dir);
              wrap_up_n   = is_up && (prev == MAX_VAL);
              wrap_down_n = is_down && (prev == '0);
            end else if (is_hold) begin
              hold_n = 1'b1;
            end else begin
              // Resync: the bad sample becomes the new reference.
              step_err_n  = 1'b1;
              dir_valid_n = 1'b0;
              state_n     = ST_ACQ;
            end
          end
          default: begin
            state_n = ST_INIT;
          end
        endcase
      end
    end
  end

  // State, reference sample and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_INIT;
      prev      <= '0;
      dir       <= 1'b0;
      dir_valid <= 1'b0;
      wrap_up   <= 1'b0;
      wrap_down <= 1'b0;
      hold      <= 1'b0;
      reversal  <= 1'b0;
      step_err  <= 1'b0;
      range_err <= 1'b0;
    end else begin
      state     <= state_n;
      prev      <= prev_n;
      dir       <= dir_n;
      dir_valid <= dir_valid_n;
      wrap_up   <= wrap_up_n;
      wrap_down <= wrap_down_n;
      hold      <= hold_n;
      reversal  <= reversal_n;
      step_err  <= step_err_n;
      range_err <= range_err_n;
    end
  end

`ifdef UDC_REV_COUNT_EN
  logic [7:0] rev_cnt_q;

  // Saturating reversal counter, updated on the same edge that raises the reversal pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      rev_cnt_q <= 8'd0;
    end else if (reversal_n && (rev_cnt_q != 8'hFF)) begin
      rev_cnt_q <= rev_cnt_q + 8'd1;
    end
  end

  assign rev_cnt = rev_cnt_q;
`else
  assign rev_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_udc_dir_decoder.sv
// Directed bench for udc_dir_decoder: one MODULUS=16 instance and one decade instance.
// Flag vectors are packed {dir, dir_valid, wrap_up, wrap_down, hold, reversal, step_err, range_err}.
`timescale 1ns/1ps
module tb_udc_dir_decoder;

`ifdef UDC_REV_COUNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] q16, q10;
  logic       en16, en10;

  logic       dir16, dv16, wu16, wd16, hd16, rv16, se16, re16;
  logic       dir10, dv10, wu10, wd10, hd10, rv10, se10, re10;
  logic [7:0] cnt16, cnt10;
  logic [7:0] o16, o10;

  int n_checks = 0;
  int n_errors = 0;

  assign o16 = {dir16, dv16, wu16, wd16, hd16, rv16, se16, re16};
  assign o10 = {dir10, dv10, wu10, wd10, hd10, rv10, se10, re10};

  udc_dir_decoder #(.WIDTH(4), .MODULUS(16)) dut16 (
    .clk(clk), .rst(rst), .q_in(q16), .q_en(en16),
    .dir(dir16), .dir_valid(dv16), .wrap_up(wu16), .wrap_down(wd16), .hold(hd16),
    .reversal(rv16), .step_err(se16), .range_err(re16), .rev_cnt(cnt16)
  );

  udc_dir_decoder #(.WIDTH(4), .MODULUS(10)) dut10 (
    .clk(clk), .rst(rst), .q_in(q10), .q_en(en10),
    .dir(dir10), .dir_valid(dv10), .wrap_up(wu10), .wrap_down(wd10), .hold(hd10),
    .reversal(rv10), .step_err(se10), .range_err(re10), .rev_cnt(cnt10)
  );

  // Clock and reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  // Drivers: present a sample at the falling edge, let one rising edge take it,
  // then look at the registered outputs 1 ns later.
  task automatic drive16(input logic [3:0] q);
    @(negedge clk);
    q16  = q;
    en16 = 1'b1;
    @(posedge clk);
    #1;
    en16 = 1'b0;
  endtask

  task automatic send16(input logic [3:0] q, input logic [7:0] exp, input string tag);
    drive16(q);
    check(tag, o16, exp);
  endtask

  task automatic send10(input logic [3:0] q, input logic [7:0] exp, input string tag);
    @(negedge clk);
    q10  = q;
    en10 = 1'b1;
    @(posedge clk);
    #1;
    en10 = 1'b0;
    check(tag, o10, exp);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_o16", o16, 8'h00);
    check("mid_rst_cnt", cnt16, 8'h00);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst  = 1'b1;
    q16  = 4'd0;
    q10  = 4'd0;
    en16 = 1'b0;
    en10 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_o16", o16, 8'h00);
    check("rst_o10", o10, 8'h00);
    check("rst_cnt", cnt16, 8'h00);
    @(negedge clk);
    rst = 1'b0;

    // Acquire upward lock
    send16(4'd0, 8'h00, "t1_first");
    send16(4'd1, 8'hC0, "t1_lock_up");
    send16(4'd2, 8'hC0, "t1_up2");
    send16(4'd3, 8'hC0, "t1_up3");

    // Count down through the wrap, then turn around and wrap up
    send16(4'd2,  8'h44, "t2_rev_down");
    send16(4'd1,  8'h40, "t2_dn1");
    send16(4'd0,  8'h40, "t2_dn0");
    send16(4'd15, 8'h50, "t2_wrap_down");
    send16(4'd14, 8'h40, "t2_dn14");
    send16(4'd15, 8'hC4, "t2_rev_up");
    send16(4'd0,  8'hE0, "t2_wrap_up");
    check("t2_cnt", cnt16, CNT_ON ? 8'd2 : 8'd0);

    // Illegal step drops the lock and resyncs on the bad sample
    send16(4'd1, 8'hC0, "t3_up1");
    send16(4'd2, 8'hC0, "t3_up2");
    send16(4'd3, 8'hC0, "t3_up3");
    send16(4'd7, 8'h82, "t3_step_err");
    send16(4'd8, 8'hC0, "t3_relock");
    send16(4'd8, 8'hC8, "t3_hold_track");

    // Idle cycle: nothing sampled, pulses low, lock kept
    @(negedge clk);
    @(posedge clk);
    #1;
    check("t3_idle", o16, 8'hC0);

    // Decade stream, including out-of-range samples
    send10(4'd12, 8'h01, "t4_range_init");
    send10(4'd8,  8'h00, "t4_first");
    send10(4'd9,  8'hC0, "t4_lock_up");
    send10(4'd0,  8'hE0, "t4_wrap_up");
    send10(4'd12, 8'hC1, "t4_range12");
    send10(4'd10, 8'hC1, "t4_range10");
    send10(4'd1,  8'hC0, "t4_up_after_range");
    send10(4'd1,  8'hC8, "t4_hold");
    send10(4'd0,  8'h44, "t4_rev_down");
    send10(4'd9,  8'h50, "t4_wrap_down");

    // Mid-stream reset drops the lock; relock downwards
    pulse_reset();
    send16(4'd5, 8'h00, "t5_first");
    send16(4'd5, 8'h08, "t5_hold_acq");
    send16(4'd4, 8'h40, "t5_lock_down");

    // Reversal counting from a fresh lock
    pulse_reset();
    send16(4'd4, 8'h00, "t6_first");
    send16(4'd5, 8'hC0, "t6_lock_up");
    send16(4'd6, 8'hC0, "t6_up6");
    send16(4'd5, 8'h44, "t6_rev1");
    send16(4'd6, 8'hC4, "t6_rev2");
    send16(4'd5, 8'h44, "t6_rev3");
    check("t6_cnt3", cnt16, CNT_ON ? 8'd3 : 8'd0);

    // 260 further reversals: counter must stop at 255
    for (int i = 0; i < 130; i++) begin
      drive16(4'd6);
      drive16(4'd5);
    end
    check("t6_sat_cnt", cnt16, CNT_ON ? 8'd255 : 8'd0);
    send16(4'd6, 8'hC4, "t6_rev_after_sat");
    check("t6_sat_hold", cnt16, CNT_ON ? 8'd255 : 8'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
